// File: rtl/lsu_pkg.sv
// Shared types and encodings for the RV32I load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StAccess   = 2'd1,
        StComplete = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [3:0] STRB_NONE    = 4'b0000;
    localparam logic [3:0] STRB_BYTE    = 4'b0001;
    localparam logic [3:0] STRB_HALF_LO = 4'b0011;
    localparam logic [3:0] STRB_HALF_HI = 4'b1100;
    localparam logic [3:0] STRB_WORD    = 4'b1111;

    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        if (is_load) begin
            return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        end
        return f3 inside {F3_B, F3_H, F3_W};
    endfunction

    // Only meaningful for legal codes; bit 1:0 of funct3 carries the access size.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] ea_lo);
        case (f3[1:0])
            2'b01:   return ea_lo[0];
            2'b10:   return ea_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] ea_lo);
        case (f3)
            F3_B:    return STRB_BYTE << ea_lo;
            F3_H:    return ea_lo[1] ? STRB_HALF_HI : STRB_HALF_LO;
            F3_W:    return STRB_WORD;
            default: return STRB_NONE;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] sdata);
        case (f3)
            F3_B:    return {4{sdata[7:0]}};
            F3_H:    return {2{sdata[15:0]}};
            default: return sdata;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data lane select and sign/zero extension.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  ea_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (ea_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = ea_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = rdata;
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'd0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store stage: memory req/ready handshake, load alignment,
// register-file writeback and fault reporting (misalign, illegal funct3, timeout).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_load,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] sdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic        rf_we,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST =
        (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    lsu_state_e state_q, state_d;

    logic            is_load_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic [31:0]     ea_q;
    logic [3:0]      strb_q;
    logic [31:0]     wdata_q;
    logic [31:0]     result_q;
    logic            fault_q;
    logic [WD_W-1:0] wd_q;

    logic [31:0] ea;
    logic        early_fault;
    logic        wd_expire;
    logic [31:0] load_result;

    assign ea          = base + offset;
    assign early_fault = !f3_legal(is_load, funct3) || misaligned(funct3, ea[1:0]);
    assign wd_expire   = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);

    load_align u_load_align (
        .rdata  (mem_rdata),
        .ea_lo  (ea_q[1:0]),
        .funct3 (funct3_q),
        .result (load_result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = early_fault ? StComplete : StAccess;
                end
            end
            StAccess: begin
                if (mem_ready || wd_expire) begin
                    state_d = StComplete;
                end
            end
            StComplete: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_load_q <= 1'b0;
            funct3_q  <= 3'd0;
            rd_q      <= 5'd0;
            ea_q      <= 32'd0;
            strb_q    <= STRB_NONE;
            wdata_q   <= 32'd0;
            result_q  <= 32'd0;
            fault_q   <= 1'b0;
            wd_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    wd_q <= '0;
                    if (start) begin
                        is_load_q <= is_load;
                        funct3_q  <= funct3;
                        rd_q      <= rd;
                        ea_q      <= ea;
                        strb_q    <= is_load ? STRB_NONE : store_strobe(funct3, ea[1:0]);
                        wdata_q   <= store_data(funct3, sdata);
                        fault_q   <= early_fault;
                    end
                end
                StAccess: begin
                    if (mem_ready) begin
                        if (is_load_q) begin
                            result_q <= load_result;
                        end
                    end else if (wd_expire) begin
                        fault_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: wd_q <= '0;
            endcase
        end
    end

    // Every output is a decode of registered state so nothing combinational leaks out.
    assign mem_req   = (state_q == StAccess);
    assign busy      = (state_q == StAccess);
    assign done      = (state_q == StComplete);
    assign fault     = done && fault_q;
    assign rf_we     = done && is_load_q && !fault_q && (rd_q != 5'd0);
    assign mem_addr  = {ea_q[31:2], 2'b00};
    assign mem_wstrb = mem_req ? strb_q : STRB_NONE;
    assign mem_wdata = wdata_q;
    assign rf_rd     = rd_q;
    assign rf_wdata  = result_q;

endmodule
